// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer: FSM state encoding,
// cause-vector bit positions and the flush counter width.
package exc_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_SERVICE = 3'd2,
    S_RETURN  = 3'd3,
    S_HALT    = 3'd4
  } state_e;

  localparam int unsigned CAUSE_W  = 3;
  localparam int unsigned CAUSE_IF = 0;
  localparam int unsigned CAUSE_ID = 1;
  localparam int unsigned CAUSE_EX = 2;

  // Flush counter holds FLUSH_CYCLES-1, with FLUSH_CYCLES in 1..15.
  localparam int unsigned FCNT_W = 4;

  typedef logic [CAUSE_W-1:0] cause_t;

endpackage

// File: rtl/exc_priority_enc.sv
// Combinational oldest-first selector for pipeline error sources.
// Ports:
//   err_if_ovf, err_id_ctrl, err_ex_alu : error flags from IF / ID / EX
//   epc_if, epc_id, epc_ex              : instruction addresses per stage
//   any_err                             : at least one error flag set
//   cause                               : one-hot winner {ex, id, if}
//   epc                                 : address of the winning instruction
module exc_priority_enc
  import exc_pkg::*;
#(
  parameter int unsigned AW = 16
) (
  input  logic          err_if_ovf,
  input  logic          err_id_ctrl,
  input  logic          err_ex_alu,
  input  logic [AW-1:0] epc_if,
  input  logic [AW-1:0] epc_id,
  input  logic [AW-1:0] epc_ex,
  output logic          any_err,
  output cause_t        cause,
  output logic [AW-1:0] epc
);

  assign any_err = err_if_ovf | err_id_ctrl | err_ex_alu;

  // EX holds the oldest instruction, so it wins over ID, which wins over IF.
  always_comb begin
    cause = '0;
    epc   = '0;
    if (err_ex_alu) begin
      cause[CAUSE_EX] = 1'b1;
      epc             = epc_ex;
    end else if (err_id_ctrl) begin
      cause[CAUSE_ID] = 1'b1;
      epc             = epc_id;
    end else if (err_if_ovf) begin
      cause[CAUSE_IF] = 1'b1;
      epc             = epc_if;
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// Central exception controller for the 5-stage pipeline. Picks the oldest
// faulting instruction, flushes the pipe, redirects fetch to the service
// routine, records cause/EPC, returns to EPC on ERET and halts on a fault
// raised while servicing.
// Ports:
//   clk, reset (async, active-low)
//   err_if_ovf, err_id_ctrl, err_ex_alu : stage error levels
//   epc_if, epc_id, epc_ex              : per-stage instruction addresses
//   eret                                : return-from-exception pulse
//   force_flush, pc_hold                : pipeline flush / PC write stall
//   redirect_vld, redirect_addr         : one-cycle PC load request and target
//   cause, epc                          : latched one-hot cause and faulting PC
//   in_service, halted                  : handler running / double fault
//   err_count                           : saturating accepted-exception count
module exception_sequencer
  import exc_pkg::*;
#(
  parameter int unsigned   AW           = 16,
  parameter logic [AW-1:0] ISR_ADDR     = '0,
  parameter int unsigned   FLUSH_CYCLES = 2,
  parameter int unsigned   CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             err_if_ovf,
  input  logic             err_id_ctrl,
  input  logic             err_ex_alu,
  input  logic [AW-1:0]    epc_if,
  input  logic [AW-1:0]    epc_id,
  input  logic [AW-1:0]    epc_ex,
  input  logic             eret,
  output logic             force_flush,
  output logic             pc_hold,
  output logic             redirect_vld,
  output logic [AW-1:0]    redirect_addr,
  output logic [2:0]       cause,
  output logic [AW-1:0]    epc,
  output logic             in_service,
  output logic             halted,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

  logic          any_err;
  cause_t        sel_cause;
  logic [AW-1:0] sel_epc;

  exc_priority_enc #(
    .AW (AW)
  ) u_prio (
    .err_if_ovf  (err_if_ovf),
    .err_id_ctrl (err_id_ctrl),
    .err_ex_alu  (err_ex_alu),
    .epc_if      (epc_if),
    .epc_id      (epc_id),
    .epc_ex      (epc_ex),
    .any_err     (any_err),
    .cause       (sel_cause),
    .epc         (sel_epc)
  );

  state_e             state_q,   state_d;
  logic [FCNT_W-1:0]  fcnt_q,    fcnt_d;
  logic               flush_q,   flush_d;
  logic               hold_q,    hold_d;
  logic               rvld_q,    rvld_d;
  logic [AW-1:0]      raddr_q,   raddr_d;
  cause_t             cause_q,   cause_d;
  logic [AW-1:0]      epc_q,     epc_d;
  logic               insvc_q,   insvc_d;
  logic               halted_q,  halted_d;
  logic [CNT_W-1:0]   errcnt_q,  errcnt_d;
  logic [CNT_W-1:0]   errcnt_inc;

  assign errcnt_inc = (errcnt_q == '1) ? errcnt_q : errcnt_q + CNT_W'(1);

  // Each state's block sets the registered output values seen in the
  // following cycle, so outputs describe the state being entered.
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    flush_d  = 1'b0;
    hold_d   = 1'b0;
    rvld_d   = 1'b0;
    raddr_d  = raddr_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    insvc_d  = 1'b0;
    halted_d = 1'b0;
    errcnt_d = errcnt_q;

    unique case (state_q)
      S_IDLE: begin
        // eret without a pending exception is ignored.
        if (any_err) begin
          state_d  = S_FLUSH;
          cause_d  = sel_cause;
          epc_d    = sel_epc;
          errcnt_d = errcnt_inc;
          raddr_d  = ISR_ADDR;
          rvld_d   = 1'b1;
          flush_d  = 1'b1;
          hold_d   = 1'b1;
          fcnt_d   = FLUSH_LOAD;
        end
      end

      S_FLUSH: begin
        // Errors here come from wrong-path instructions being flushed.
        if (fcnt_q == '0) begin
          state_d = S_SERVICE;
          insvc_d = 1'b1;
        end else begin
          fcnt_d  = fcnt_q - FCNT_W'(1);
          flush_d = 1'b1;
          hold_d  = 1'b1;
        end
      end

      S_SERVICE: begin
        if (any_err) begin
          // Double fault wins over a simultaneous eret; cause/epc keep the
          // original exception for post-mortem.
          state_d  = S_HALT;
          halted_d = 1'b1;
          flush_d  = 1'b1;
          hold_d   = 1'b1;
          errcnt_d = errcnt_inc;
        end else if (eret) begin
          state_d = S_RETURN;
          raddr_d = epc_q;
          rvld_d  = 1'b1;
          flush_d = 1'b1;
          hold_d  = 1'b1;
          insvc_d = 1'b1;
          fcnt_d  = FLUSH_LOAD;
        end else begin
          insvc_d = 1'b1;
        end
      end

      S_RETURN: begin
        if (fcnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          fcnt_d  = fcnt_q - FCNT_W'(1);
          flush_d = 1'b1;
          hold_d  = 1'b1;
          insvc_d = 1'b1;
        end
      end

      S_HALT: begin
        halted_d = 1'b1;
        flush_d  = 1'b1;
        hold_d   = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      fcnt_q   <= '0;
      flush_q  <= 1'b0;
      hold_q   <= 1'b0;
      rvld_q   <= 1'b0;
      raddr_q  <= ISR_ADDR;
      cause_q  <= '0;
      epc_q    <= '0;
      insvc_q  <= 1'b0;
      halted_q <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      flush_q  <= flush_d;
      hold_q   <= hold_d;
      rvld_q   <= rvld_d;
      raddr_q  <= raddr_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      insvc_q  <= insvc_d;
      halted_q <= halted_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign force_flush   = flush_q;
  assign pc_hold       = hold_q;
  assign redirect_vld  = rvld_q;
  assign redirect_addr = raddr_q;
  assign cause         = cause_q;
  assign epc           = epc_q;
  assign in_service    = insvc_q;
  assign halted        = halted_q;
  assign err_count     = errcnt_q;

endmodule
